// File: rtl/sobel_pkg.sv
// sobel_pkg: shared state type, window size and credit-width helper for the Sobel frame sequencer
package sobel_pkg;

  localparam int WINDOW = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROW,
    SHIFT,
    CONV,
    WAIT_CONV,
    ROW_END,
    DONE
  } state_t;

  // Bits needed to count 0..rows inclusive
  function automatic int credit_w(input int rows);
    return $clog2(rows + 1);
  endfunction

endpackage

// File: rtl/sobel_row_credit.sv
// sobel_row_credit: counts rows held by the line buffer and flags a write into a full buffer
module sobel_row_credit
  import sobel_pkg::*;
#(
  parameter int BUF_ROWS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          row_done,
  input  logic                          row_release,
  output logic [credit_w(BUF_ROWS)-1:0] rows_ready,
  output logic                          overflow
);

  localparam int CW = credit_w(BUF_ROWS);

  // Load adds a credit, release removes one; a load into a full buffer is dropped and latched as overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_ready <= '0;
      overflow   <= 1'b0;
    end else if (row_done && !row_release) begin
      if (rows_ready == CW'(BUF_ROWS)) overflow <= 1'b1;
      else rows_ready <= rows_ready + 1'b1;
    end else if (row_release && !row_done && rows_ready != '0) begin
      rows_ready <= rows_ready - 1'b1;
    end
  end

endmodule

// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer: sweeps a 3x3 window over buffered rows and sequences one convolution per output pixel
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int IMG_W    = 16,
  parameter int IMG_H    = 16,
  parameter int BUF_ROWS = 4
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     image_start,
  input  logic                     row_done,
  input  logic                     conv_done,
  output logic                     shift_data,
  output logic                     convolve_start,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic                     row_release,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     overflow
);

  localparam int CLW = $clog2(IMG_W);
  localparam int RLW = $clog2(IMG_H);
  localparam int CW  = credit_w(BUF_ROWS);

  state_t          state;
  logic [CLW-1:0]  col_idx;
  logic [RLW-1:0]  row_idx;
  logic [CW-1:0]   rows_ready;

  sobel_row_credit #(.BUF_ROWS(BUF_ROWS)) u_credit (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .row_done   (row_done),
    .row_release(row_release),
    .rows_ready (rows_ready),
    .overflow   (overflow)
  );

  // Frame FSM; each strobe is registered together with the state it belongs to so it lasts exactly that state's cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state          <= IDLE;
      col_idx        <= '0;
      row_idx        <= '0;
      shift_data     <= 1'b0;
      convolve_start <= 1'b0;
      row_release    <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
      out_col        <= '0;
      out_row        <= '0;
    end else begin
      shift_data     <= 1'b0;
      convolve_start <= 1'b0;
      row_release    <= 1'b0;
      frame_done     <= 1'b0;
      case (state)
        IDLE: if (image_start) begin
          state   <= WAIT_ROW;
          col_idx <= '0;
          row_idx <= '0;
          busy    <= 1'b1;
        end
        WAIT_ROW: if (rows_ready >= CW'(WINDOW)) begin
          state      <= SHIFT;
          shift_data <= 1'b1;
        end
        SHIFT: if (col_idx >= CLW'(WINDOW - 1)) begin
          state          <= CONV;
          convolve_start <= 1'b1;
          out_col        <= col_idx - CLW'(WINDOW - 1);
          out_row        <= row_idx;
        end else begin
          col_idx    <= col_idx + 1'b1;
          shift_data <= 1'b1;
        end
        CONV: state <= WAIT_CONV;
        WAIT_CONV: if (conv_done) begin
          if (col_idx == CLW'(IMG_W - 1)) begin
            state       <= ROW_END;
            row_release <= 1'b1;
          end else begin
            state      <= SHIFT;
            col_idx    <= col_idx + 1'b1;
            shift_data <= 1'b1;
          end
        end
        ROW_END: if (row_idx == RLW'(IMG_H - WINDOW)) begin
          state      <= DONE;
          frame_done <= 1'b1;
        end else begin
          state   <= WAIT_ROW;
          row_idx <= row_idx + 1'b1;
          col_idx <= '0;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// tb_sobel_frame_sequencer: randomized scoreboard bench for the Sobel frame sequencer
module tb_sobel_frame_sequencer;
  import sobel_pkg::*;

  localparam int W = 5;
  localparam int H = 4;
  localparam int B = 4;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic image_start = 1'b0;
  logic row_done = 1'b0;
  logic conv_done = 1'b0;
  logic shift_data, convolve_start, row_release, frame_done, busy, overflow;
  logic [$clog2(W)-1:0] out_col;
  logic [$clog2(H)-1:0] out_row;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int n_shift = 0;
  int n_rel = 0;
  int n_strobe = 0;
  int frames = 0;
  int conv_delay = 1;
  int pend = 0;
  bit noise = 1'b0;
  int mon_s;
  int mon_e;

  sobel_frame_sequencer #(.IMG_W(W), .IMG_H(H), .BUF_ROWS(B)) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .image_start   (image_start),
    .row_done      (row_done),
    .conv_done     (conv_done),
    .shift_data    (shift_data),
    .convolve_start(convolve_start),
    .out_col       (out_col),
    .out_row       (out_row),
    .row_release   (row_release),
    .frame_done    (frame_done),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expected pixels on every convolve strobe and audits per-frame totals
  always @(negedge HCLK) if (HRESETn) begin
    mon_s = int'(shift_data) + int'(convolve_start) + int'(row_release) + int'(frame_done);
    if (mon_s > 0) begin
      chk("strobe_exclusive", mon_s, 1);
      chk("busy_during_strobe", int'(busy), 1);
    end
    n_strobe += mon_s;
    if (shift_data) n_shift++;
    if (row_release) n_rel++;
    if (convolve_start) begin
      chk("conv_expected_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("conv_pixel_row100_col", int'(out_row) * 100 + int'(out_col), mon_e);
      end
    end
    if (frame_done) begin
      chk("frame_pixels_left", exp_q.size(), 0);
      chk("frame_shifts", n_shift, W * (H - 2));
      chk("frame_releases", n_rel, H - 2);
      n_shift = 0;
      n_rel = 0;
      frames++;
    end
  end

  // Convolution engine stand-in: answers each convolve strobe after a delay, optionally glitching conv_done during shifts
  initial forever begin
    @(negedge HCLK);
    conv_done = 1'b0;
    if (!HRESETn) pend = 0;
    else if (pend > 0) begin
      pend--;
      conv_done = (pend == 0);
    end else if (convolve_start) pend = (conv_delay > 0) ? conv_delay : int'($urandom_range(1, 3));
    if (HRESETn && noise && shift_data && $urandom_range(0, 1) == 1) conv_done = 1'b1;
  end

  task automatic flush();
    exp_q.delete();
    n_shift = 0;
    n_rel = 0;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    flush();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic rows(input int n);
    repeat (n) begin
      @(negedge HCLK);
      row_done = 1'b1;
      @(negedge HCLK);
      row_done = 1'b0;
    end
  endtask

  // Reference model: every output pixel of the frame in raster order, encoded row*100+col
  task automatic start_frame();
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++)
        exp_q.push_back(r * 100 + c);
    @(negedge HCLK);
    image_start = 1'b1;
    @(negedge HCLK);
    image_start = 1'b0;
  endtask

  task automatic wait_frame(input int lim);
    int f;
    int i;
    f = frames;
    i = 0;
    while (frames == f && i < lim) begin
      @(negedge HCLK);
      i++;
    end
    chk("frame_completed", int'(frames != f), 1);
  endtask

  initial begin
    int i;
    int s;
    #1;
    @(negedge HCLK);
    chk("reset_outputs", int'({shift_data, convolve_start, row_release, frame_done, busy, overflow}), 0);
    chk("reset_rows_ready", int'(dut.rows_ready), 0);
    chk("reset_state", int'(dut.state), int'(IDLE));
    HRESETn = 1'b1;

    rows(5);
    chk("preload_rows_ready", int'(dut.rows_ready), 4);
    chk("preload_overflow", int'(overflow), 1);
    conv_delay = 1;
    start_frame();
    wait_frame(400);
    @(negedge HCLK);
    chk("busy_after_frame", int'(busy), 0);
    chk("overflow_sticky", int'(overflow), 1);
    chk("rows_after_frame", int'(dut.rows_ready), 2);

    conv_delay = 0;
    noise = 1'b1;
    rows(2);
    start_frame();
    wait_frame(600);
    noise = 1'b0;
    chk("rows_after_random_frame", int'(dut.rows_ready), 2);

    do_reset();
    conv_delay = 1;
    rows(3);
    start_frame();
    i = 0;
    do begin @(negedge HCLK); i++; end while (!row_release && i < 300);
    chk("stall_release_seen", int'(row_release), 1);
    @(negedge HCLK);
    s = n_strobe;
    repeat (15) @(negedge HCLK);
    chk("stall_no_strobes", n_strobe - s, 0);
    chk("stall_busy", int'(busy), 1);
    chk("stall_state", int'(dut.state), int'(WAIT_ROW));
    chk("stall_rows_ready", int'(dut.rows_ready), 2);
    rows(1);
    wait_frame(400);
    chk("rows_after_stall_frame", int'(dut.rows_ready), 2);

    do_reset();
    rows(3);
    start_frame();
    i = 0;
    do begin @(negedge HCLK); i++; end while (!row_release && i < 300);
    chk("coincident_release_seen", int'(row_release), 1);
    row_done = 1'b1;
    @(negedge HCLK);
    row_done = 1'b0;
    chk("coincident_rows_ready", int'(dut.rows_ready), 3);
    chk("coincident_overflow", int'(overflow), 0);
    wait_frame(400);
    chk("rows_after_coincident_frame", int'(dut.rows_ready), 2);

    do_reset();
    rows(4);
    conv_delay = 20;
    noise = 1'b1;
    start_frame();
    i = 0;
    do begin @(negedge HCLK); i++; end while (!convolve_start && i < 300);
    chk("slow_conv_seen", int'(convolve_start), 1);
    @(negedge HCLK);
    s = n_strobe;
    repeat (15) @(negedge HCLK);
    chk("slow_conv_no_strobes", n_strobe - s, 0);
    chk("slow_conv_state", int'(dut.state), int'(WAIT_CONV));
    wait_frame(1500);
    noise = 1'b0;
    conv_delay = 1;

    do_reset();
    rows(4);
    start_frame();
    i = 0;
    do begin @(negedge HCLK); i++; end while (!(convolve_start && out_row == 1) && i < 300);
    chk("row1_conv_seen", int'(convolve_start && out_row == 1), 1);
    @(posedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("midreset_outputs", int'({shift_data, convolve_start, row_release, frame_done, busy, overflow}), 0);
    chk("midreset_state", int'(dut.state), int'(IDLE));
    chk("midreset_rows_ready", int'(dut.rows_ready), 0);
    flush();
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    rows(4);
    start_frame();
    wait_frame(400);
    @(negedge HCLK);
    chk("busy_after_reset_frame", int'(busy), 0);
    chk("rows_after_reset_frame", int'(dut.rows_ready), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
